// File: rtl/draw_number.sv
// draw_number: overlays an unsigned value as a right-aligned, DIGITS-wide
// decimal field on the VGA stream. A sequential double-dabble engine converts
// the value to BCD; the result is committed to the displayed digits only during
// vertical blanking. Glyph rows come from the shared 8x16 font ROM.
// Optional feature macro: DRAW_NUMBER_LEAD_ZERO_BLANK_EN (leading zeros drawn
// transparent; least-significant digit always drawn).

package draw_number_pkg;
  typedef struct packed {
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_bus_t;
endpackage

module draw_number
  import draw_number_pkg::*;
#(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned VALUE_W    = 14,
  parameter int unsigned POS_X      = 480,
  parameter int unsigned POS_Y      = 376,
  parameter int unsigned SCALE_LOG2 = 0,
  parameter logic [11:0] FONT_COLOR = 12'hFFF,
  parameter logic [7:0]  CHAR_BASE  = 8'h30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [VALUE_W-1:0] value,
  input  logic               value_valid,
  output logic               value_ready,
  output logic               overflow,
  input  vga_bus_t           bus_in,
  output vga_bus_t           bus_out,
  input  logic [7:0]         char_pixels,
  output logic [10:0]        address
);

  // Decimal digits needed to hold 2^w - 1.
  function automatic int unsigned num_dec_digits(input int unsigned w);
    longint unsigned v;
    int unsigned     n;
    v = (64'd1 << w) - 64'd1;
    n = 0;
    while (v != 64'd0) begin
      n = n + 1;
      v = v / 64'd10;
    end
    return n;
  endfunction

  localparam int unsigned GW      = 8 << SCALE_LOG2;
  localparam int unsigned GH      = 16 << SCALE_LOG2;
  localparam int unsigned FIELD_W = DIGITS * GW;
  localparam int unsigned BCD_REQ = num_dec_digits(VALUE_W);
  localparam int unsigned BCD_N   = (BCD_REQ > DIGITS) ? BCD_REQ : DIGITS;
  localparam int unsigned CNT_W   = $clog2(VALUE_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_WAIT} state_t;

  state_t                   state_q, state_d;
  logic [VALUE_W-1:0]       val_q, val_d;
  logic [BCD_N-1:0][3:0]    bcd_q, bcd_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [DIGITS-1:0][3:0]   disp_q, disp_d;
  logic [DIGITS-1:0]        blank_q, blank_d;
  logic                     ovf_q, ovf_d;

  logic [3:0] nib;
  logic       carry;
  logic       ovf_det;
  logic       zero_run;

  assign value_ready = (state_q == S_IDLE);
  assign overflow    = ovf_q;

  // Converter FSM: accept, double-dabble for VALUE_W cycles, commit in vblank.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d  = state_q;
    val_d    = val_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    disp_d   = disp_q;
    blank_d  = blank_q;
    ovf_d    = ovf_q;
    nib      = '0;
    carry    = 1'b0;
    ovf_det  = 1'b0;
    zero_run = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (value_valid) begin
          val_d   = value;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        // Add-3 on nibbles >= 5, then shift left pulling in the value MSB.
        carry = val_q[VALUE_W-1];
        for (int i = 0; i < BCD_N; i++) begin
          nib      = (bcd_q[i] >= 4'd5) ? bcd_q[i] + 4'd3 : bcd_q[i];
          bcd_d[i] = {nib[2:0], carry};
          carry    = nib[3];
        end
        val_d = val_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(VALUE_W - 1)) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus_in.vblnk) begin
          for (int i = DIGITS; i < BCD_N; i++) begin
            if (bcd_q[i] != 4'd0) ovf_det = 1'b1;
          end
          for (int i = 0; i < DIGITS; i++) begin
            disp_d[i] = ovf_det ? 4'd9 : bcd_q[i];
          end
          ovf_d   = ovf_det;
          blank_d = '0;
`ifdef DRAW_NUMBER_LEAD_ZERO_BLANK_EN
          zero_run = 1'b1;
          for (int i = DIGITS - 1; i > 0; i--) begin
            zero_run   = zero_run && (disp_d[i] == 4'd0);
            blank_d[i] = zero_run;
          end
`endif
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Converter state and displayed digits; reset aborts any conversion.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= S_IDLE;
      val_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      blank_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      blank_q <= blank_d;
      ovf_q   <= ovf_d;
    end
  end

  // Stage-1 geometry: field hit, glyph column/row and font address.
  logic [31:0] dx, dy, dig_idx;
  logic        in_field;
  logic [2:0]  col;
  logic [3:0]  row;
  logic [3:0]  sel_digit;
  logic        sel_blank;
  logic [6:0]  code;
  logic [10:0] addr_d;

  always_comb begin
    dx       = 32'(bus_in.hcount) - POS_X;
    dy       = 32'(bus_in.vcount) - POS_Y;
    in_field = (32'(bus_in.hcount) >= POS_X) && (32'(bus_in.hcount) < POS_X + FIELD_W) &&
               (32'(bus_in.vcount) >= POS_Y) && (32'(bus_in.vcount) < POS_Y + GH);
    dig_idx  = dx >> (3 + SCALE_LOG2);
    col      = 3'(dx >> SCALE_LOG2);
    row      = 4'(dy >> SCALE_LOG2);
    sel_digit = '0;
    sel_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_idx == 32'(i)) begin
        sel_digit = disp_q[DIGITS-1-i];
        sel_blank = blank_q[DIGITS-1-i];
      end
    end
    code   = 7'(CHAR_BASE) + 7'(sel_digit);
    addr_d = in_field ? {code, row} : '0;
  end

  vga_bus_t    s1_q;
  logic [10:0] address_q;
  logic        in_q, blank1_q, en_q;
  logic [2:0]  col_q;

  // Stage-1 registers: bus copy plus pixel attributes for stage 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= '0;
      address_q <= '0;
      in_q      <= 1'b0;
      blank1_q  <= 1'b0;
      en_q      <= 1'b0;
      col_q     <= '0;
    end else begin
      s1_q      <= bus_in;
      address_q <= addr_d;
      in_q      <= in_field;
      blank1_q  <= sel_blank;
      en_q      <= enable;
      col_q     <= col;
    end
  end

  assign address = address_q;

  // Stage-2 pixel mux: font bit 7 is the leftmost glyph column.
  vga_bus_t bus_d;
  always_comb begin
    bus_d = s1_q;
    if (en_q && in_q && !blank1_q && char_pixels[3'd7 - col_q]) bus_d.rgb = FONT_COLOR;
  end

  vga_bus_t bus_q;

  // Stage-2 output register.
  always_ff @(posedge clk) begin
    if (rst) bus_q <= '0;
    else     bus_q <= bus_d;
  end

  assign bus_out = bus_q;

endmodule

// File: tb/tb_draw_number.sv
// tb_draw_number: directed bench for draw_number with a combinational font ROM
// model. A second instance runs with SCALE_LOG2=1 to cover glyph scaling.

module tb_draw_number;
  import draw_number_pkg::*;

  localparam int VW = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, enable, value_valid;
  logic [VW-1:0] value;
  vga_bus_t      bus_in, bus_out, bus_out_s;
  logic          value_ready, value_ready_s, overflow, overflow_s;
  logic [7:0]    char_pixels, char_pixels_s;
  logic [10:0]   address, address_s;

  int n_tests = 0;
  int n_fail  = 0;

  // Font ROM stand-in: deterministic, non-symmetric rows.
  function automatic logic [7:0] font_rom(input logic [10:0] a);
    return a[7:0] ^ 8'hE1 ^ {a[10:8], 5'b0};
  endfunction

  assign char_pixels   = font_rom(address);
  assign char_pixels_s = font_rom(address_s);

  draw_number u_dut (
    .clk(clk), .rst(rst), .enable(enable), .value(value), .value_valid(value_valid),
    .value_ready(value_ready), .overflow(overflow), .bus_in(bus_in), .bus_out(bus_out),
    .char_pixels(char_pixels), .address(address)
  );

  draw_number #(.SCALE_LOG2(1)) u_dut_s (
    .clk(clk), .rst(rst), .enable(enable), .value(value), .value_valid(value_valid),
    .value_ready(value_ready_s), .overflow(overflow_s), .bus_in(bus_in), .bus_out(bus_out_s),
    .char_pixels(char_pixels_s), .address(address_s)
  );

  typedef struct {
    int          h;
    int          v;
    logic [11:0] rgb;
    logic        chk_addr;
    logic [10:0] exp_addr;
    logic [11:0] exp_rgb;
  } vec_t;

  vec_t     vecs[13];
  vga_bus_t hist[0:1023];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bus(input int h, input int v, input logic vb, input logic [11:0] rgb);
    bus_in.hcount = 11'(h);
    bus_in.vcount = 11'(v);
    bus_in.hsync  = h[0];
    bus_in.hblnk  = h[1];
    bus_in.vsync  = v[0];
    bus_in.vblnk  = vb;
    bus_in.rgb    = rgb;
  endtask

  function automatic vga_bus_t rand_bus(input int vmax);
    vga_bus_t b;
    b.hcount = 11'($urandom_range(0, 1055));
    b.vcount = 11'($urandom_range(0, vmax));
    b.hsync  = 1'($urandom);
    b.hblnk  = 1'($urandom);
    b.vsync  = 1'($urandom);
    b.vblnk  = 1'($urandom);
    b.rgb    = 12'($urandom);
    return b;
  endfunction

  // Hold one pixel for two cycles: check address after stage 1, rgb after stage 2.
  task automatic pix(input string nm, input int h, input int v, input logic [11:0] rgb,
                     input logic chk_addr, input logic [10:0] exp_addr,
                     input logic [11:0] exp_rgb, input logic scaled);
    set_bus(h, v, 1'b0, rgb);
    tick();
    if (chk_addr) check({nm, " addr"}, scaled ? address_s : address, exp_addr);
    tick();
    check({nm, " rgb"}, scaled ? bus_out_s.rgb : bus_out.rgb, exp_rgb);
  endtask

  // Read the four displayed digits back through the font address of row 0.
  task automatic check_disp(input string nm, input logic [15:0] ds);
    logic [3:0] d;
    for (int k = 0; k < 4; k++) begin
      d = ds[15-4*k -: 4];
      set_bus(480 + 8 * k, 376, 1'b0, 12'h000);
      tick();
      check($sformatf("%s digit%0d", nm, k), address, 11'h300 + 11'(d) * 11'd16);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!value_ready && n < 100) begin
      tick();
      n++;
    end
    if (!value_ready) check("wait_ready timeout", 0, 1);
  endtask

  // Offer a value with vblnk held high: commit lands on WAIT entry.
  task automatic commit(input logic [VW-1:0] v);
    int n = 0;
    wait_ready();
    set_bus(0, 500, 1'b1, 12'h000);
    value       = v;
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    while (!value_ready && n < 100) begin
      tick();
      n++;
    end
    check($sformatf("commit %0d busy cycles", v), n, VW + 1);
  endtask

  task automatic accept_novblank(input logic [VW-1:0] v);
    wait_ready();
    set_bus(0, 500, 1'b0, 12'h000);
    value       = v;
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int idx;
    logic [11:0] lz_rgb;

    vecs[0]  = '{480, 376, 12'h101, 1'b1, 11'h300, 12'hFFF};
    vecs[1]  = '{481, 376, 12'h102, 1'b1, 11'h300, 12'h102};
    vecs[2]  = '{487, 376, 12'h103, 1'b1, 11'h300, 12'hFFF};
    vecs[3]  = '{487, 377, 12'h104, 1'b1, 11'h301, 12'h104};
    vecs[4]  = '{480, 377, 12'h105, 1'b1, 11'h301, 12'hFFF};
    vecs[5]  = '{510, 391, 12'h106, 1'b1, 11'h30F, 12'hFFF};
    vecs[6]  = '{511, 391, 12'h107, 1'b1, 11'h30F, 12'h107};
    vecs[7]  = '{508, 391, 12'h108, 1'b1, 11'h30F, 12'hFFF};
    vecs[8]  = '{494, 383, 12'h109, 1'b1, 11'h307, 12'hFFF};
    vecs[9]  = '{479, 376, 12'h10A, 1'b0, 11'h000, 12'h10A};
    vecs[10] = '{512, 376, 12'h10B, 1'b0, 11'h000, 12'h10B};
    vecs[11] = '{480, 392, 12'h10C, 1'b0, 11'h000, 12'h10C};
    vecs[12] = '{480, 375, 12'h10D, 1'b0, 11'h000, 12'h10D};

    rst = 1'b1; enable = 1'b1; value_valid = 1'b0; value = '0;
    set_bus(700, 200, 1'b1, 12'hABC);
    repeat (3) tick();
    check("reset bus_out", bus_out, 38'd0);
    check("reset address", address, 11'd0);
    check("reset overflow", overflow, 1'b0);
    check("reset value_ready", value_ready, 1'b1);
    rst = 1'b0;

    // Pass-through latency on pixels outside the field.
    for (int i = 0; i < 24; i++) begin
      hist[i] = rand_bus(300);
      bus_in  = hist[i];
      tick();
      if (i >= 1) check($sformatf("stream %0d", i), bus_out, hist[i-1]);
    end

    for (int i = 0; i < 13; i++) begin
      pix($sformatf("vec%0d", i), vecs[i].h, vecs[i].v, vecs[i].rgb,
          vecs[i].chk_addr, vecs[i].exp_addr, vecs[i].exp_rgb, 1'b0);
    end
    check_disp("reset disp", 16'h0000);

    // 1234 offered outside vblank: display holds until the first vblnk cycle.
    wait_ready();
    set_bus(496, 381, 1'b0, 12'h222);
    value = 14'd1234;
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    repeat (20) tick();
    check("1234 ready low while waiting", value_ready, 1'b0);
    check("1234 digits held", address, 11'h305);
    bus_in.vblnk = 1'b1;
    tick();
    check("1234 ready after commit", value_ready, 1'b1);
    check("1234 addr old on commit edge", address, 11'h305);
    bus_in.vblnk = 1'b0;
    tick();
    check("1234 addr new digit", address, 11'h335);
    check_disp("1234 disp", 16'h1234);
    pix("1234 d2r5c0", 496, 381, 12'h201, 1'b1, 11'h335, 12'hFFF, 1'b0);
    pix("1234 d2r5c1", 497, 381, 12'h202, 1'b1, 11'h335, 12'h202, 1'b0);
    pix("1234 d2r5c2", 498, 381, 12'h203, 1'b1, 11'h335, 12'hFFF, 1'b0);

    // Overflow saturates to 9999, a later small value clears it.
    commit(14'd12000);
    check("12000 overflow", overflow, 1'b1);
    check_disp("12000 disp", 16'h9999);
    commit(14'd7);
    check("7 overflow", overflow, 1'b0);
    check_disp("7 disp", 16'h0007);
`ifdef DRAW_NUMBER_LEAD_ZERO_BLANK_EN
    lz_rgb = 12'h301;
`else
    lz_rgb = 12'hFFF;
`endif
    pix("7 leading digit", 480, 376, 12'h301, 1'b1, 11'h300, lz_rgb, 1'b0);
    pix("7 last digit", 504, 376, 12'h302, 1'b1, 11'h370, 12'hFFF, 1'b0);

    // 2x scaling on the second instance: 64x32 field, 2x2 pixel blocks.
    commit(14'd8);
    pix("s1 c0 a", 528, 380, 12'h401, 1'b1, 11'h382, 12'h401, 1'b1);
    pix("s1 c0 b", 529, 381, 12'h402, 1'b1, 11'h382, 12'h402, 1'b1);
    pix("s1 c5",   539, 380, 12'h403, 1'b1, 11'h382, 12'h403, 1'b1);
    pix("s1 c6 a", 540, 380, 12'h404, 1'b1, 11'h382, 12'hFFF, 1'b1);
    pix("s1 c6 b", 541, 381, 12'h405, 1'b1, 11'h382, 12'hFFF, 1'b1);
    pix("s1 c7",   542, 380, 12'h406, 1'b1, 11'h382, 12'hFFF, 1'b1);
    pix("s1 r15 c7", 543, 407, 12'h407, 1'b1, 11'h38F, 12'h407, 1'b1);
    pix("s1 r15 c6", 540, 407, 12'h408, 1'b1, 11'h38F, 12'hFFF, 1'b1);
    pix("s1 right out", 544, 380, 12'h409, 1'b0, 11'h000, 12'h409, 1'b1);
    pix("s1 bottom out", 528, 408, 12'h40A, 1'b0, 11'h000, 12'h40A, 1'b1);
    pix("s1 digit0", 480, 376, 12'h40B, 1'b1, 11'h300, 12'hFFF, 1'b1);

    // value_valid held during conversion: only the first value is taken.
    accept_novblank(14'd4321);
    for (int i = 0; i < 16; i++) begin
      value = 14'd5678;
      value_valid = 1'b1;
      tick();
    end
    value_valid = 1'b0;
    check("spam busy", value_ready, 1'b0);
    bus_in.vblnk = 1'b1;
    tick();
    check("spam commit ready", value_ready, 1'b1);
    bus_in.vblnk = 1'b0;
    repeat (2) tick();
    check("spam stays idle", value_ready, 1'b1);
    check_disp("spam disp", 16'h4321);

    // Reset mid-conversion clears display and overflow.
    commit(14'd12000);
    check("pre-reset overflow", overflow, 1'b1);
    accept_novblank(14'd1111);
    repeat (5) tick();
    check("mid conv busy", value_ready, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst ready", value_ready, 1'b1);
    check("rst overflow", overflow, 1'b0);
    set_bus(0, 500, 1'b1, 12'h000);
    repeat (20) tick();
    check("rst no late commit", value_ready, 1'b1);
    check_disp("rst disp", 16'h0000);

    // enable=0: rgb is a pure 2-clk delay across the whole field.
    commit(14'd5555);
    enable = 1'b0;
    idx = 0;
    for (int v = 376; v < 392; v++) begin
      for (int h = 478; h < 514; h++) begin
        set_bus(h, v, 1'b0, 12'($urandom));
        hist[idx] = bus_in;
        tick();
        if (idx >= 1) check($sformatf("en0 %0d", idx), bus_out, hist[idx-1]);
        idx++;
      end
    end
    enable = 1'b1;
    pix("5555 en1 glyph", 480, 376, 12'h501, 1'b1, 11'h350, 12'hFFF, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
